// File: rtl/am_ctrl_pkg.sv
// Shared encodings and defaults for the AM stream controller.
package am_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic SRC_HOST = 1'b0;
    localparam logic SRC_TEST = 1'b1;

    localparam int DEFAULT_TIMEOUT = 100000;

    // Saturating increment for an up-to-32-bit counter value of the given width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        if (value >= max_v) begin
            sat_inc = max_v;
        end else begin
            sat_inc = value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/am_prefetch_buf.sv
// Two-deep prefetch stage: buf_data_r holds the next word, out_r is what the modulator sees.
module am_prefetch_buf (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       refill_en,
    input  logic       src_empty,
    input  logic [7:0] src_sample,
    input  logic       prime_load,
    input  logic       consume,
    output logic       pop,
    output logic [7:0] out_sample,
    output logic       buf_valid,
    output logic       out_loaded
);

    logic [7:0] out_r;
    logic [7:0] buf_data_r;
    logic       buf_valid_r;
    logic       out_loaded_r;
    logic       load_s;

    // Pop and move decisions; a pop needs an empty buffer, a move needs a full one.
    always_comb begin
        pop    = 1'b0;
        load_s = 1'b0;
        if (refill_en && !buf_valid_r && !src_empty) begin
            pop = 1'b1;
        end else begin
            pop = 1'b0;
        end
        if (buf_valid_r && ((prime_load && !out_loaded_r) || consume)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // Stage registers: capture on pop, shift buffer into output on load.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_r        <= 8'h00;
            buf_data_r   <= 8'h00;
            buf_valid_r  <= 1'b0;
            out_loaded_r <= 1'b0;
        end else if (pop) begin
            buf_data_r  <= src_sample;
            buf_valid_r <= 1'b1;
        end else if (load_s) begin
            out_r        <= buf_data_r;
            buf_valid_r  <= 1'b0;
            out_loaded_r <= 1'b1;
        end
    end

    assign out_sample = out_r;
    assign buf_valid  = buf_valid_r;
    assign out_loaded = out_loaded_r;

endmodule

// File: rtl/am_stream_ctrl.sv
// Sequences the AM PWM modulator and feeds it from one of two FWFT sources,
// stopping only on symbol boundaries and auto-stopping on prolonged starvation.
module am_stream_ctrl
    import am_ctrl_pkg::*;
#(
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 src_sel,
    input  logic [7:0]           s0_sample,
    input  logic                 s0_empty,
    output logic                 s0_read,
    input  logic [7:0]           s1_sample,
    input  logic                 s1_empty,
    output logic                 s1_read,
    output logic [7:0]           mod_sample,
    output logic                 mod_empty,
    input  logic                 mod_read,
    input  logic                 mod_symb_clk,
    output logic                 mod_enable,
    output logic                 mod_rst,
    output logic                 busy,
    output logic                 auto_stopped,
    output logic [CNT_WIDTH-1:0] underflow_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t               state_r;
    state_t               state_s;
    logic                 src_r;
    logic [TW-1:0]        starve_timer_r;
    logic [TW-1:0]        drain_timer_r;
    logic                 starved_prev_r;
    logic                 symb_prev_r;
    logic [CNT_WIDTH-1:0] underflow_cnt_r;
    logic                 auto_stopped_r;

    logic       sel_empty_s;
    logic [7:0] sel_sample_s;
    logic       refill_en_s;
    logic       pop_s;
    logic       buf_valid_s;
    logic       out_loaded_s;
    logic       starved_s;
    logic       starve_hit_s;
    logic       drain_hit_s;
    logic       toggle_s;
    logic       accept_start_s;

    // Source mux and per-cycle condition decode.
    always_comb begin
        sel_empty_s    = 1'b1;
        sel_sample_s   = 8'h00;
        if (src_r == SRC_TEST) begin
            sel_empty_s  = s1_empty;
            sel_sample_s = s1_sample;
        end else begin
            sel_empty_s  = s0_empty;
            sel_sample_s = s0_sample;
        end
        // A pop in the cycle that leaves PRIME/RUN would only be thrown away.
        refill_en_s    = ((state_r == ST_PRIME) || (state_r == ST_RUN)) && !stop && !rst;
        starved_s      = (state_r == ST_RUN) && !buf_valid_s && sel_empty_s;
        starve_hit_s   = starved_s && (starve_timer_r == TIMER_LAST);
        drain_hit_s    = (drain_timer_r == TIMER_LAST);
        toggle_s       = mod_symb_clk ^ symb_prev_r;
        accept_start_s = (state_r == ST_IDLE) && start && !stop;
    end

    am_prefetch_buf u_prefetch (
        .clk        (clk),
        .rst        (rst),
        .flush      (state_r == ST_IDLE),
        .refill_en  (refill_en_s),
        .src_empty  (sel_empty_s),
        .src_sample (sel_sample_s),
        .prime_load (state_r == ST_PRIME),
        .consume    ((state_r == ST_RUN) && mod_read),
        .pop        (pop_s),
        .out_sample (mod_sample),
        .buf_valid  (buf_valid_s),
        .out_loaded (out_loaded_s)
    );

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_start_s) begin
                    state_s = ST_PRIME;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRIME: begin
                if (stop) begin
                    state_s = ST_IDLE;
                end else if (out_loaded_s && buf_valid_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_PRIME;
                end
            end
            ST_RUN: begin
                if (stop || starve_hit_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (toggle_s || drain_hit_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state.
    always_comb begin
        mod_enable = 1'b0;
        mod_rst    = 1'b1;
        mod_empty  = 1'b1;
        case (state_r)
            ST_IDLE: begin
                mod_enable = 1'b0;
                mod_rst    = 1'b1;
                mod_empty  = 1'b1;
            end
            ST_PRIME: begin
                mod_enable = 1'b0;
                mod_rst    = 1'b0;
                mod_empty  = 1'b1;
            end
            ST_RUN: begin
                mod_enable = 1'b1;
                mod_rst    = 1'b0;
                mod_empty  = !buf_valid_s;
            end
            ST_DRAIN: begin
                mod_enable = 1'b1;
                mod_rst    = 1'b0;
                mod_empty  = 1'b1;
            end
            default: begin
                mod_enable = 1'b0;
                mod_rst    = 1'b1;
                mod_empty  = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Source latch and symbol-clock history.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_r       <= SRC_HOST;
            symb_prev_r <= 1'b0;
        end else begin
            symb_prev_r <= mod_symb_clk;
            if (accept_start_s) begin
                src_r <= src_sel;
            end
        end
    end

    // Starvation and drain timers.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_timer_r <= '0;
            drain_timer_r  <= '0;
            starved_prev_r <= 1'b0;
        end else begin
            starved_prev_r <= starved_s;
            if (starved_s) begin
                starve_timer_r <= starve_timer_r + TW'(1);
            end else begin
                starve_timer_r <= '0;
            end
            if (state_r == ST_DRAIN) begin
                drain_timer_r <= drain_timer_r + TW'(1);
            end else begin
                drain_timer_r <= '0;
            end
        end
    end

    // Session statistics: underflow episodes and the auto-stop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_cnt_r <= '0;
            auto_stopped_r  <= 1'b0;
        end else if (accept_start_s) begin
            underflow_cnt_r <= '0;
            auto_stopped_r  <= 1'b0;
        end else begin
            if (starved_s && !starved_prev_r) begin
                underflow_cnt_r <= CNT_WIDTH'(sat_inc(32'(underflow_cnt_r), CNT_WIDTH));
            end
            if (starve_hit_s && !stop) begin
                auto_stopped_r <= 1'b1;
            end
        end
    end

    assign s0_read       = pop_s && (src_r == SRC_HOST);
    assign s1_read       = pop_s && (src_r == SRC_TEST);
    assign busy          = (state_r != ST_IDLE);
    assign auto_stopped  = auto_stopped_r;
    assign underflow_cnt = underflow_cnt_r;

endmodule

// File: tb/tb_am_stream_ctrl.sv
// Directed bench for am_stream_ctrl with two array-backed FWFT source models.
module tb_am_stream_ctrl;

    localparam int TMO = 50;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        src_sel;
    logic [7:0]  s0_sample;
    logic        s0_empty;
    logic        s0_read;
    logic [7:0]  s1_sample;
    logic        s1_empty;
    logic        s1_read;
    logic [7:0]  mod_sample;
    logic        mod_empty;
    logic        mod_read;
    logic        mod_symb_clk;
    logic        mod_enable;
    logic        mod_rst;
    logic        busy;
    logic        auto_stopped;
    logic [15:0] underflow_cnt;

    logic [7:0] s0_mem [0:15];
    logic [7:0] s1_mem [0:15];
    int s0_head = 0;
    int s1_head = 0;
    int s0_cnt  = 0;
    int s1_cnt  = 0;

    int checks   = 0;
    int failures = 0;

    am_stream_ctrl #(.TIMEOUT(TMO), .CNT_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .src_sel       (src_sel),
        .s0_sample     (s0_sample),
        .s0_empty      (s0_empty),
        .s0_read       (s0_read),
        .s1_sample     (s1_sample),
        .s1_empty      (s1_empty),
        .s1_read       (s1_read),
        .mod_sample    (mod_sample),
        .mod_empty     (mod_empty),
        .mod_read      (mod_read),
        .mod_symb_clk  (mod_symb_clk),
        .mod_enable    (mod_enable),
        .mod_rst       (mod_rst),
        .busy          (busy),
        .auto_stopped  (auto_stopped),
        .underflow_cnt (underflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign s0_sample = s0_mem[s0_head[3:0]];
    assign s1_sample = s1_mem[s1_head[3:0]];
    assign s0_empty  = (s0_head >= s0_cnt);
    assign s1_empty  = (s1_head >= s1_cnt);

    always @(posedge clk) begin
        if (s0_read) s0_head <= s0_head + 1;
        if (s1_read) s1_head <= s1_head + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            s0_mem[i] = 8'h00;
            s1_mem[i] = 8'h00;
        end
        rst = 1'b1; start = 1'b0; stop = 1'b0; src_sel = 1'b0;
        mod_read = 1'b0; mod_symb_clk = 1'b0;
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_mod_rst", mod_rst, 1);
        chk("rst_mod_enable", mod_enable, 0);
        chk("rst_mod_empty", mod_empty, 1);
        chk("rst_mod_sample", mod_sample, 8'h00);
        chk("rst_auto", auto_stopped, 0);
        chk("rst_ucnt", underflow_cnt, 0);
        chk("rst_s0_read", s0_read, 0);
        rst = 1'b0;
        tick(1);

        // Start and steady flow from the host source.
        s0_mem[0] = 8'h10; s0_mem[1] = 8'h20; s0_mem[2] = 8'h30; s0_cnt = 3;
        src_sel = 1'b0; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("prime_busy", busy, 1);
        chk("prime_enable", mod_enable, 0);
        chk("prime_mod_rst", mod_rst, 0);
        tick(4);
        chk("run_enable", mod_enable, 1);
        chk("run_sample", mod_sample, 8'h10);
        chk("run_empty", mod_empty, 0);
        chk("run_s0_pops", s0_head, 2);
        chk("run_s1_pops", s1_head, 0);
        mod_read = 1'b1;
        tick(1);
        mod_read = 1'b0;
        chk("read1_sample", mod_sample, 8'h20);
        chk("read1_empty", mod_empty, 1);
        tick(1);
        chk("refill_pops", s0_head, 3);
        chk("refill_empty", mod_empty, 0);
        chk("refill_ucnt", underflow_cnt, 0);

        // Starvation episodes and timeout.
        mod_read = 1'b1;
        tick(1);
        mod_read = 1'b0;
        chk("read2_sample", mod_sample, 8'h30);
        tick(1);
        chk("starve1_ucnt", underflow_cnt, 1);
        s0_mem[3] = 8'h40; s0_cnt = 4;
        tick(1);
        mod_read = 1'b1;
        tick(1);
        mod_read = 1'b0;
        chk("read3_sample", mod_sample, 8'h40);
        tick(1);
        chk("starve2_ucnt", underflow_cnt, 2);
        tick(48);
        chk("starve_pre_auto", auto_stopped, 0);
        tick(1);
        chk("starve_auto", auto_stopped, 1);
        chk("starve_drain_busy", busy, 1);
        chk("starve_drain_empty", mod_empty, 1);
        tick(3);
        mod_symb_clk = ~mod_symb_clk;
        chk("drain_wait_busy", busy, 1);
        tick(1);
        chk("symb_idle_busy", busy, 0);
        chk("symb_idle_rst", mod_rst, 1);
        chk("symb_idle_enable", mod_enable, 0);
        chk("auto_sticky", auto_stopped, 1);
        chk("ucnt_held", underflow_cnt, 2);

        // Source select: test-pattern FIFO.
        s0_mem[4] = 8'h55; s0_cnt = 5;
        s1_mem[0] = 8'hAA; s1_mem[1] = 8'hBB; s1_cnt = 2;
        src_sel = 1'b1; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("sel_auto_clr", auto_stopped, 0);
        chk("sel_ucnt_clr", underflow_cnt, 0);
        tick(4);
        chk("sel_sample", mod_sample, 8'hAA);
        chk("sel_s1_pops", s1_head, 2);
        chk("sel_s0_pops", s0_head, 4);
        chk("sel_enable", mod_enable, 1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("start_ignored", mod_enable, 1);

        // Graceful stop at the next symbol boundary.
        s1_mem[2] = 8'hCC; s1_cnt = 3;
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("stop_empty", mod_empty, 1);
        chk("stop_enable", mod_enable, 1);
        tick(19);
        chk("stop_wait_busy", busy, 1);
        mod_symb_clk = ~mod_symb_clk;
        tick(1);
        chk("stop_idle_busy", busy, 0);
        chk("stop_idle_enable", mod_enable, 0);
        chk("stop_idle_rst", mod_rst, 1);
        chk("stop_no_pops", s1_head, 2);
        chk("stop_auto", auto_stopped, 0);

        // Start and stop together, then stop during PRIME.
        start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        chk("both_idle", busy, 0);
        start = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b1;
        #1;
        chk("prime_stop_noread", s1_read, 0);
        tick(1);
        stop = 1'b0;
        chk("prime_stop_idle", busy, 0);
        chk("prime_stop_pops", s1_head, 2);

        // DRAIN with no symbol toggle leaves after exactly TMO cycles.
        s1_mem[3] = 8'hDD; s1_cnt = 4;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        chk("tmo_run_sample", mod_sample, 8'hCC);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(TMO - 1);
        chk("tmo_pre_busy", busy, 1);
        tick(1);
        chk("tmo_idle_busy", busy, 0);
        chk("tmo_auto", auto_stopped, 0);

        // Reset in RUN while a refill is pending.
        s0_mem[5] = 8'h66; s0_mem[6] = 8'h77; s0_cnt = 7;
        src_sel = 1'b0; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        chk("rr_run_sample", mod_sample, 8'h55);
        mod_read = 1'b1;
        tick(1);
        mod_read = 1'b0;
        rst = 1'b1;
        #1;
        chk("rr_no_read", s0_read, 0);
        tick(1);
        rst = 1'b0;
        chk("rr_busy", busy, 0);
        chk("rr_mod_rst", mod_rst, 1);
        chk("rr_enable", mod_enable, 0);
        chk("rr_empty", mod_empty, 1);
        chk("rr_sample", mod_sample, 8'h00);
        chk("rr_ucnt", underflow_cnt, 0);
        chk("rr_pops", s0_head, 6);
        s0_mem[7] = 8'h88; s0_cnt = 8;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        chk("restart_sample", mod_sample, 8'h77);
        chk("restart_pops", s0_head, 8);
        chk("restart_enable", mod_enable, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/am_stream_ctrl.md
Name: am_stream_ctrl

Overview:
- Sequences the AM PWM modulator and selects which of two FWFT sample sources feeds it: host stream (src 0) or test-pattern FIFO (src 1).
- Owns the modulator's enable/reset and presents it a FIFO-style sample interface through a two-deep prefetch stage.
- Stops only at sample-symbol boundaries, tracked via the modulator's symb_clk.
- Detects starvation, counts it, and auto-stops after a timeout.

Parameters:
- TIMEOUT, 100000: cycles of continuous starvation in RUN, or of waiting in DRAIN, before forced exit.
- CNT_WIDTH, 16: width of underflow_cnt.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin streaming
- stop  in  1  one-cycle request to end streaming
- src_sel  in  1  source select; latched on accepted start
- s0_sample  in  8  source 0 head word, valid when s0_empty=0
- s0_empty  in  1  source 0 empty
- s0_read  out  1  source 0 pop
- s1_sample  in  8  source 1 head word
- s1_empty  in  1  source 1 empty
- s1_read  out  1  source 1 pop
- mod_sample  out  8  sample presented to modulator
- mod_empty  out  1  to modulator empty
- mod_read  in  1  modulator pop request
- mod_symb_clk  in  1  modulator symbol-boundary toggle
- mod_enable  out  1  modulator enable
- mod_rst  out  1  modulator reset
- busy  out  1  state != IDLE
- auto_stopped  out  1  sticky: last session ended by starvation timeout
- underflow_cnt  out  CNT_WIDTH  starvation episodes this session, saturating

Behaviour:
- Clocking/reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - state=IDLE
  - mod_enable=0, mod_rst=1, mod_empty=1, mod_sample=0
  - s0_read=s1_read=0
  - busy=0, auto_stopped=0, underflow_cnt=0
  - prefetch stage emptied; timers cleared.
- Reset mid-operation discards buffered samples. No source pop occurs in the reset cycle.
- Prefetch stage: out_reg (drives mod_sample) plus buf (buf_valid).
  - Refill: when buf_valid=0, state is PRIME or RUN, and the selected source is not empty, assert the selected *_read for exactly one cycle.
  - Capture *_sample in that same cycle; buf_valid=1 next cycle.
  - The unselected read is always 0.
  - At most one pop per cycle.
- mod_empty = ~buf_valid in RUN; 1 in every other state.
- On mod_read with buf_valid=1: out_reg<=buf, buf_valid<=0. mod_sample changes exactly 1 cycle after mod_read and then holds.
- mod_read while mod_empty=1 is ignored.
- Refill and consume in the same cycle are impossible, because refill needs buf_valid=0.
- States:
  - IDLE: mod_rst=1, mod_enable=0. start=1 and stop=0 → latch src_sel, clear underflow_cnt and auto_stopped → PRIME. start and stop together → stay IDLE.
  - PRIME: mod_rst=0, mod_enable=0. The first refilled word is moved buf→out_reg, then buf refills. When out_reg is loaded and buf_valid=1 → RUN. stop → IDLE, discarding the stage.
  - RUN: mod_enable=1. start is ignored. stop → DRAIN.
    - Starvation = buf_valid=0 and selected source empty.
    - The first cycle of each starvation episode increments underflow_cnt, saturating at all-ones.
    - starve_timer counts consecutive starved cycles and clears when not starved.
    - starve_timer reaching TIMEOUT-1 → DRAIN with auto_stopped<=1.
  - DRAIN: mod_enable=1, mod_empty=1, no source pops.
    - Exit → IDLE on the first detected toggle of mod_symb_clk (registered edge detect; 1-cycle detect latency).
    - Also exit → IDLE after TIMEOUT cycles without a toggle.
    - stop/start are ignored.
- The prefetched word left in buf at stop is discarded, not returned to the source.
- mod_rst returns to 1 in the cycle IDLE is entered.

Decomposition:
- Package am_ctrl_pkg holds:
  - state encodings (ST_IDLE, ST_PRIME, ST_RUN, ST_DRAIN)
  - SRC_HOST=0, SRC_TEST=1
  - the default TIMEOUT constant
- One sub-module, am_prefetch_buf: out_reg/buf pair with refill and consume logic.
- The FSM, timers, counter and source mux stay in am_stream_ctrl.

Test Plan:
- Start and steady flow: src_sel=0, s0 preloaded 0x10,0x20,0x30; start → two s0_read pulses, mod_sample=0x10, RUN; mod_read → mod_sample=0x20 next cycle and one more s0_read; s1_read stays 0.
- Source select: src_sel=1, s1 holds 0xAA, s0 holds 0x55 → only s1_read pulses, mod_sample=0xAA.
- Starvation: RUN with the source drained; mod_read twice separated by refills → underflow_cnt=1 per episode; hold empty TIMEOUT=50 cycles → DRAIN, auto_stopped=1, then IDLE after a mod_symb_clk toggle.
- Graceful stop: stop in RUN → mod_empty=1 immediately; mod_symb_clk toggles 20 cycles later → IDLE, mod_enable=0, mod_rst=1, no extra source pops.
- Edge requests: start and stop together in IDLE → stays IDLE; stop in PRIME → IDLE; DRAIN with no toggle → IDLE after exactly TIMEOUT cycles.
- Reset mid-RUN: rst=1 for one cycle → all outputs at reset values, underflow_cnt=0, no reads that cycle; restart works.
